// File: rtl/bus_interface_unit.sv
// Burst bus master: turns a core request into len+1 memory beats with an
// optional not-ready timeout. The FSM walks IDLE -> ACCESS -> DONE.
module bus_interface_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] data_read,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              read_write,
    output logic [DATA_W-1:0] data_write,
    output logic              beat_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;

    logic              burst_we;
    logic [ADDR_W-1:0] burst_base;
    logic [LEN_W-1:0]  burst_len;
    logic [LEN_W-1:0]  beat_idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_inc;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic              timed_out;
    logic              in_access;
    logic              beat_accept;
    logic              timeout_hit;

    // Saturating increment so the wait counter can never wrap, even with the timeout disabled.
    assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    assign in_access    = (state == ACCESS);
    assign cur_addr     = burst_base + ADDR_W'(beat_idx);

    always_comb begin
        state_next  = state;
        beat_accept = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_next = ACCESS;
            end
            ACCESS: begin
                if (mem_ready) begin
                    beat_accept = 1'b1;
                    if (beat_idx == burst_len) state_next = DONE;
                end else if ((TIMEOUT != 0) && (wait_cnt_inc == CNT_LIMIT)) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs: the bus is only driven in ACCESS; the address parks on its last value.
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        error      = (state == DONE) && timed_out;
        address    = in_access ? cur_addr : last_addr;
        read_write = in_access ? ~burst_we : 1'b1;
        data_write = (in_access && burst_we) ? wdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_idx   <= '0;
            wait_cnt   <= '0;
            timed_out  <= 1'b0;
            beat_valid <= 1'b0;
            rdata      <= '0;
            last_addr  <= '0;
        end else begin
            state      <= state_next;
            beat_valid <= beat_accept;
            if (in_access) last_addr <= cur_addr;
            if (beat_accept && !burst_we) rdata <= data_read;
            case (state)
                IDLE: begin
                    if (req) begin
                        beat_idx  <= '0;
                        wait_cnt  <= '0;
                        timed_out <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (beat_accept) begin
                        wait_cnt <= '0;
                        if (beat_idx != burst_len) beat_idx <= beat_idx + 1'b1;
                    end else begin
                        wait_cnt  <= wait_cnt_inc;
                        timed_out <= timeout_hit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Burst descriptor is pure data captured with the request; it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            burst_we   <= we;
            burst_base <= addr;
            burst_len  <= len;
        end
    end

endmodule

// File: doc/bus_interface_unit.md
BUS_INTERFACE_UNIT -- requirements
Module: bus_interface_unit

Interface
REQ-001 Parameter ADDR_W, default 16, address bus width.
REQ-002 Parameter DATA_W, default 8, data bus width.
REQ-003 Parameter LEN_W, default 2, burst-length field width; beats per burst = len+1.
REQ-004 Parameter TIMEOUT, default 15, consecutive not-ready cycles before abort; 0 disables the timeout.
REQ-005 clk  in  1  single system clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req  in  1  core transaction request; sampled only in IDLE.
REQ-008 we  in  1  1 = write burst, 0 = read burst; captured with req.
REQ-009 addr  in  ADDR_W  burst base address; captured with req.
REQ-010 len  in  LEN_W  beats minus one; captured with req.
REQ-011 wdata  in  DATA_W  write data for the current beat; core holds it until that beat's beat_valid.
REQ-012 mem_ready  in  1  memory completes the current beat this cycle.
REQ-013 data_read  in  DATA_W  memory read data; valid when mem_ready=1.
REQ-014 busy  out  1  high in every non-IDLE state.
REQ-015 address  out  ADDR_W  memory address.
REQ-016 read_write  out  1  1 = read, 0 = write.
REQ-017 data_write  out  DATA_W  memory write data.
REQ-018 beat_valid  out  1  registered one-cycle pulse per completed beat.
REQ-019 rdata  out  DATA_W  registered read data; updated with beat_valid, held otherwise.
REQ-020 done  out  1  one-cycle pulse at burst end.
REQ-021 error  out  1  one-cycle pulse, coincident with done, on timeout abort.

Function
REQ-022 FSM states IDLE, ACCESS, DONE; the state register changes only on the clock edge or on reset.
REQ-023 IDLE: req=1 -> capture we/addr/len, clear beat index and wait counter -> ACCESS; req=0 -> stay in IDLE.
REQ-024 ACCESS: address = base + beat index, modulo 2^ADDR_W (wraps 0xFFFF->0x0000 at default width).
REQ-025 ACCESS: read_write = ~we; data_write = wdata when we=1, else 0.
REQ-026 Outside ACCESS: read_write = 1, data_write = 0, address holds the last driven value.
REQ-027 ACCESS with mem_ready=1: next cycle beat_valid=1 and rdata=data_read (read bursts only; write bursts leave rdata unchanged); wait counter is cleared.
REQ-028 Accepted beat with index < len: increment index and stay in ACCESS; index == len: go to DONE.
REQ-029 ACCESS with mem_ready=0: wait counter increments by 1.
REQ-030 TIMEOUT != 0 and the wait counter reaches TIMEOUT -> DONE with error, no beat_valid; mem_ready=1 in that same cycle takes priority over the timeout.
REQ-031 DONE: done=1 for one cycle, error=1 only for a timeout abort, then IDLE unconditionally.
REQ-032 The last beat's beat_valid coincides with done.
REQ-033 Latency with mem_ready held high: req sampled at edge 0, first ACCESS cycle is cycle 1, done is in cycle 2+len.
REQ-034 req while busy=1 is ignored and not queued; req in the DONE cycle is ignored.
REQ-035 The wait counter is ceil(log2(TIMEOUT+1)) bits wide, minimum 1, and never wraps.

Reset
REQ-036 rst=1 immediately forces IDLE, including mid-burst with no done pulse.
REQ-037 While rst=1: busy, beat_valid, done, error = 0; address = 0; rdata = 0; data_write = 0; read_write = 1; beat index and wait counter = 0.
REQ-038 The first req is honoured at the first rising edge after rst falls.

Verification
REQ-039 Read burst: addr=0x1234, len=3, mem_ready=1, memory returns 0xA0..0xA3 -> address 0x1234..0x1237 in cycles 1-4; beat_valid in cycles 2-5 with rdata 0xA0..0xA3; done in cycle 5; error=0.
REQ-040 Wrap: addr=0xFFFE, len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-041 Write with wait states: we=1, len=0, wdata=0x5A, mem_ready low 3 cycles then high -> read_write=0 and data_write=0x5A for 4 cycles; beat_valid and done together one cycle later.
REQ-042 Timeout: TIMEOUT=15, mem_ready stuck low -> done=1 and error=1 after 15 ACCESS cycles, no beat_valid; repeat with mem_ready rising on cycle 15 -> beat accepted, error=0.
REQ-043 Reset mid-burst: assert rst during beat 2 of len=3 -> busy=0 and address=0 without a clock edge; no done; a new req after release starts a clean burst.
REQ-044 Ignored request: pulse req during ACCESS -> burst unchanged, exactly one done, FSM returns to IDLE.
